// File: rtl/wiper_pkg.sv
// Shared types and defaults for the wiper arm actuator.
// The speed encoding matches what the rain/wiper controller emits.
package wiper_pkg;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2
  } speed_t;

  typedef enum logic [1:0] {
    PARK       = 2'd0,
    SWEEP_OUT  = 2'd1,
    SWEEP_BACK = 2'd2
  } arm_state_t;

  localparam int DEFAULT_NPOS        = 8;
  localparam int DEFAULT_SLOW_DIV    = 4;
  localparam int DEFAULT_FAST_DIV    = 2;
  localparam int DEFAULT_NCOUNT_BITS = 8;

  // Only slow and fast move the arm; off and the illegal code 3 both mean "stop".
  function automatic logic is_run_speed(input logic [1:0] s);
    return (s == SPD_SLOW) || (s == SPD_FAST);
  endfunction

endpackage

// File: rtl/wiper_step_timer.sv
// Step pacing counter: emits a one-cycle step pulse every SLOW_DIV or
// FAST_DIV cycles while enabled, and sits at zero while disabled.
module wiper_step_timer #(
  parameter int SLOW_DIV = wiper_pkg::DEFAULT_SLOW_DIV,
  parameter int FAST_DIV = wiper_pkg::DEFAULT_FAST_DIV
) (
  input  logic clk_2,
  input  logic reset,
  input  logic enable,
  input  logic div_sel,
  output logic step
);

  localparam int TW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_DIV - 1);
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST_DIV - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [TW-1:0] last;

  // Step fires on the last count of the selected divisor; the count restarts after each step.
  always_comb begin
    last    = div_sel ? FAST_LAST : SLOW_LAST;
    step    = enable && (timer_q == last);
    timer_d = timer_q;
    if (!enable || step) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Timer register with synchronous reset.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/wiper_arm_driver.sv
// Wiper arm actuator: sweeps the arm across the LED bar at the commanded
// pace and always finishes a sweep back to park before stopping.
module wiper_arm_driver
  import wiper_pkg::*;
#(
  parameter int NPOS        = DEFAULT_NPOS,
  parameter int SLOW_DIV    = DEFAULT_SLOW_DIV,
  parameter int FAST_DIV    = DEFAULT_FAST_DIV,
  parameter int NCOUNT_BITS = DEFAULT_NCOUNT_BITS
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic [1:0]               speed,
  output logic [$clog2(NPOS)-1:0]  arm_pos,
  output logic [NPOS-1:0]          arm_led,
  output logic                     parked,
  output logic [NCOUNT_BITS-1:0]   sweep_count,
  output logic [1:0]               cur_speed
);

  localparam int PW = $clog2(NPOS);
  localparam logic [PW-1:0] LAST_POS = PW'(NPOS - 1);

  arm_state_t             state_q, state_d;
  logic [PW-1:0]          pos_q, pos_d;
  logic [NCOUNT_BITS-1:0] count_q, count_d;
  logic [1:0]             cur_speed_q, cur_speed_d;
  logic                   step;
  logic                   run_cmd;

  assign run_cmd = is_run_speed(speed);

  wiper_step_timer #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_timer (
    .clk_2   (clk_2),
    .reset   (reset),
    .enable  (state_q != PARK),
    .div_sel (cur_speed_q == SPD_FAST),
    .step    (step)
  );

  // Next-state logic: leave park on a run command, move one position per step,
  // and decide at the end of each return sweep whether to park or go again.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    count_d     = count_q;
    cur_speed_d = cur_speed_q;
    unique case (state_q)
      PARK: begin
        pos_d = '0;
        if (run_cmd) begin
          state_d     = SWEEP_OUT;
          cur_speed_d = speed;
        end
      end
      SWEEP_OUT: begin
        if (step) begin
          pos_d = pos_q + PW'(1);
          if (run_cmd) cur_speed_d = speed;
          if (pos_d == LAST_POS) state_d = SWEEP_BACK;
        end
      end
      SWEEP_BACK: begin
        if (step) begin
          pos_d = pos_q - PW'(1);
          if (run_cmd) cur_speed_d = speed;
          if (pos_d == '0) begin
            count_d = count_q + NCOUNT_BITS'(1);
            if (run_cmd) begin
              state_d = SWEEP_OUT;
            end else begin
              state_d     = PARK;
              cur_speed_d = SPD_OFF;
            end
          end
        end
      end
      default: begin
        state_d     = PARK;
        pos_d       = '0;
        cur_speed_d = SPD_OFF;
      end
    endcase
  end

  // Arm FSM registers; reset parks the arm immediately, even mid-sweep.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= PARK;
      pos_q       <= '0;
      count_q     <= '0;
      cur_speed_q <= SPD_OFF;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      count_q     <= count_d;
      cur_speed_q <= cur_speed_d;
    end
  end

  assign arm_pos     = pos_q;
  assign arm_led     = {{(NPOS-1){1'b0}}, 1'b1} << pos_q;
  assign parked      = (state_q == PARK);
  assign sweep_count = count_q;
  assign cur_speed   = cur_speed_q;

endmodule

// File: tb/tb_wiper_arm_driver.sv
// Testbench for wiper_arm_driver: a sweep-phase reference model predicts the
// arm position, park flag, sweep count and governing speed every cycle.
module tb_wiper_arm_driver;

  localparam int N        = 8;
  localparam int SLOW     = 4;
  localparam int FAST     = 2;
  localparam int SWEEP    = 2 * (N - 1);

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] speed = 2'd0;
  logic [2:0] arm_pos;
  logic [7:0] arm_led;
  logic       parked;
  logic [7:0] sweep_count;
  logic [1:0] cur_speed;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a sweep is a phase 0..SWEEP-1, position folds back after the far end.
  bit m_parked = 1'b1;
  int m_phase  = 0;
  int m_count  = 0;
  int m_speed  = 0;
  int m_wait   = 0;

  wiper_arm_driver dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .speed       (speed),
    .arm_pos     (arm_pos),
    .arm_led     (arm_led),
    .parked      (parked),
    .sweep_count (sweep_count),
    .cur_speed   (cur_speed)
  );

  always #5 clk_2 = ~clk_2;

  function automatic int div_of(input int s);
    return (s == 2) ? FAST : SLOW;
  endfunction

  function automatic bit is_run(input int s);
    return (s == 1) || (s == 2);
  endfunction

  task automatic model_step(input int s, input bit r);
    if (r) begin
      m_parked = 1'b1; m_phase = 0; m_count = 0; m_speed = 0; m_wait = 0;
    end else if (m_parked) begin
      if (is_run(s)) begin
        m_parked = 1'b0; m_speed = s; m_wait = div_of(s);
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_phase++;
        if (is_run(s)) m_speed = s;
        if (m_phase == SWEEP) begin
          m_phase = 0;
          m_count = (m_count + 1) % 256;
          if (!is_run(s)) begin
            m_parked = 1'b1; m_speed = 0;
          end
        end
        m_wait = div_of(m_speed);
      end
    end
  endtask

  function automatic int model_pos();
    return (m_phase <= N - 1) ? m_phase : SWEEP - m_phase;
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [7:0] led;
    int p;
    p   = model_pos();
    led = 8'd1 << p;
    return {3'(p), led, m_parked, 8'(m_count), 2'(m_speed)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {arm_pos, arm_led, parked, sweep_count, cur_speed};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle before sampling.
  task automatic cycle(input int s, input bit r);
    speed = 2'(s);
    reset = r;
    @(posedge clk_2);
    model_step(s, r);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1'b1);
    cycle(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1'b0);
      n_checks++;
      if ({parked, arm_pos, arm_led, sweep_count} !== {1'b1, 3'd0, 8'b0000_0001, 8'd0})
        $display("[TB] FAIL reset_idle cycle %0d: got %h, exp %h", i,
                 {parked, arm_pos, arm_led, sweep_count}, {1'b1, 3'd0, 8'b0000_0001, 8'd0});
      else n_pass++;
    end
  endtask

  task automatic test_fast_sweep();
    cycle(0, 1'b1);
    for (int e = 1; e <= 60; e++) begin
      cycle(2, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL fast_sweep edge %0d: got %h, exp %h", e, dut_vec(), exp_vec());
      else n_pass++;
      if (e == 1 || e == 3 || e == 15 || e == 29) begin
        logic [3:0] want;
        want = (e == 1) ? 4'd0 : (e == 3) ? 4'd1 : (e == 15) ? 4'd7 : 4'd0;
        n_checks++;
        if ({parked, arm_pos} !== want)
          $display("[TB] FAIL fast_landmark edge %0d: got %h, exp %h", e, {parked, arm_pos}, want);
        else n_pass++;
      end
      if (e == 29) begin
        n_checks++;
        if (sweep_count !== 8'd1)
          $display("[TB] FAIL fast_count edge 29: got %0d, exp 1", sweep_count);
        else n_pass++;
      end
    end
  endtask

  task automatic test_slow_to_off();
    bit found = 1'b0;
    cycle(0, 1'b1);
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(1, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL slow_run cycle %0d: got %h, exp %h", i, dut_vec(), exp_vec());
      else n_pass++;
      if (m_count == 1 && m_phase == SWEEP - 3) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("[TB] FAIL slow_reach_pos3: got not reached, exp reached");
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL slow_off cycle %0d: got %h, exp %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({parked, arm_pos, sweep_count, cur_speed} !== {1'b1, 3'd0, 8'd2, 2'd0})
      $display("[TB] FAIL slow_off_final: got %h, exp %h",
               {parked, arm_pos, sweep_count, cur_speed}, {1'b1, 3'd0, 8'd2, 2'd0});
    else n_pass++;
  endtask

  task automatic test_speed_change();
    bit found = 1'b0;
    int e3 = -1;
    int e4 = -1;
    cycle(0, 1'b1);
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 1'b0);
      if (m_phase == 2) found = 1'b1;
    end
    n_checks++;
    if (!found || arm_pos !== 3'd2) $display("[TB] FAIL chg_reach_pos2: got %0d, exp 2", arm_pos);
    else n_pass++;
    for (int e = 1; e <= 60; e++) begin
      cycle(2, 1'b0);
      if (e3 < 0 && arm_pos == 3'd3) e3 = e;
      if (e4 < 0 && arm_pos == 3'd4) e4 = e;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL speed_change edge %0d: got %h, exp %h", e, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (e3 != 4 || e4 != 6)
      $display("[TB] FAIL chg_pacing: got steps at %0d/%0d, exp 4/6", e3, e4);
    else n_pass++;
    n_checks++;
    if (cur_speed !== 2'd2) $display("[TB] FAIL chg_cur_speed: got %0d, exp 2", cur_speed);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    cycle(0, 1'b1);
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(2, 1'b0);
      if (m_phase == 5) found = 1'b1;
    end
    n_checks++;
    if (!found || arm_pos !== 3'd5) $display("[TB] FAIL mid_reach_pos5: got %0d, exp 5", arm_pos);
    else n_pass++;
    cycle(2, 1'b1);
    n_checks++;
    if ({parked, arm_pos, sweep_count, cur_speed} !== {1'b1, 3'd0, 8'd0, 2'd0})
      $display("[TB] FAIL mid_reset: got %h, exp %h",
               {parked, arm_pos, sweep_count, cur_speed}, {1'b1, 3'd0, 8'd0, 2'd0});
    else n_pass++;
    cycle(2, 1'b0);
    n_checks++;
    if ({parked, arm_pos, cur_speed} !== {1'b0, 3'd0, 2'd2})
      $display("[TB] FAIL mid_restart: got %h, exp %h", {parked, arm_pos, cur_speed}, {1'b0, 3'd0, 2'd2});
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle(2, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL mid_after cycle %0d: got %h, exp %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    cycle(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(3, 1'b0);
      n_checks++;
      if ({parked, arm_pos, cur_speed} !== {1'b1, 3'd0, 2'd0})
        $display("[TB] FAIL illegal_park cycle %0d: got %h, exp %h", i,
                 {parked, arm_pos, cur_speed}, {1'b1, 3'd0, 2'd0});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int s = 0;
    int hold = 0;
    cycle(0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      bit r;
      if (hold == 0) begin
        s    = int'($urandom_range(0, 3));
        hold = int'($urandom_range(1, 60));
      end
      hold--;
      r = ($urandom_range(0, 99) == 0);
      cycle(s, r);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL random cycle %0d: got %h, exp %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    cycle(0, 1'b1);
    for (int i = 0; i < 8000 && !found; i++) begin
      cycle(2, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("[TB] FAIL wrap_preload cycle %0d: got %h, exp %h", i, dut_vec(), exp_vec());
      else n_pass++;
      if (m_count == 255) found = 1'b1;
    end
    n_checks++;
    if (!found || sweep_count !== 8'd255)
      $display("[TB] FAIL wrap_reach_255: got %0d, exp 255", sweep_count);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(2, 1'b0);
      if (m_count == 0) found = 1'b1;
    end
    n_checks++;
    if (!found || {sweep_count, parked, arm_pos} !== {8'd0, 1'b0, 3'd0})
      $display("[TB] FAIL wrap_to_zero: got %h, exp %h", {sweep_count, parked, arm_pos}, {8'd0, 1'b0, 3'd0});
    else n_pass++;
  endtask

  initial begin
    $display("[TB] wiper_arm_driver bench start");
    test_reset();
    test_fast_sweep();
    test_slow_to_off();
    test_speed_change();
    test_reset_mid_sweep();
    test_illegal();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
